// File: rtl/fx2_in_arbiter.sv
// Shares the FX2 IN byte path between the timetag sample stream and the command-reply stream.
// Switches source only at record/packet boundaries; replies have priority, tempered by a sample quota.
module fx2_in_arbiter #(
  parameter int RECORD_BYTES   = 6,
  parameter int MIN_SAMPLE_REC = 1,
  parameter int MAX_REPLY_LEN  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sample,
  input  logic       sample_rdy,
  output logic       sample_ack,
  input  logic [7:0] reply,
  input  logic       reply_rdy,
  input  logic       reply_end,
  output logic       reply_ack,
  output logic [7:0] out_data,
  output logic       out_rdy,
  input  logic       out_ack,
  output logic       out_end,
  output logic       grant_reply,
  output logic       reply_overrun,
  output logic [1:0] fsm_state
);

  // Handshake: a byte moves on a cycle where out_rdy & out_ack are both high;
  // the granted source sees its ack in that same cycle, nothing is registered.

  localparam int BW = $clog2(RECORD_BYTES);
  localparam int RW = (MAX_REPLY_LEN > 1) ? $clog2(MAX_REPLY_LEN) : 1;
  localparam int QW = (MIN_SAMPLE_REC > 0) ? $clog2(MIN_SAMPLE_REC + 1) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] REPLY  = 2'd2;

  localparam logic [BW-1:0] BCNT_LAST  = BW'(RECORD_BYTES - 1);
  localparam logic [RW-1:0] RCNT_LAST  = RW'(MAX_REPLY_LEN - 1);
  localparam logic [QW-1:0] QUOTA_LOAD = QW'(MIN_SAMPLE_REC);

  logic [1:0]    state;
  logic [BW-1:0] bcnt;
  logic [RW-1:0] rcnt;
  logic [QW-1:0] quota;
  logic          xfer;
  logic          rcnt_last;

  assign fsm_state = state;
  assign rcnt_last = (rcnt == RCNT_LAST);
  assign xfer      = out_rdy & out_ack;

  // Outputs are forced low while reset is asserted so an abandoned
  // record or packet never produces an ack or an out_end.
  always_comb begin
    out_data    = 8'h00;
    out_rdy     = 1'b0;
    out_end     = 1'b0;
    sample_ack  = 1'b0;
    reply_ack   = 1'b0;
    grant_reply = 1'b0;
    if (reset_n) begin
      case (state)
        SAMPLE: begin
          out_data   = sample;
          out_rdy    = sample_rdy;
          sample_ack = sample_rdy & out_ack;
        end
        REPLY: begin
          out_data    = reply;
          out_rdy     = reply_rdy;
          out_end     = reply_rdy & (reply_end | rcnt_last);
          reply_ack   = reply_rdy & out_ack;
          grant_reply = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bcnt          <= '0;
      rcnt          <= '0;
      quota         <= '0;
      reply_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bcnt <= '0;
          rcnt <= '0;
          if (reply_rdy && quota == '0) begin
            state <= REPLY;
          end else if (sample_rdy) begin
            state <= SAMPLE;
          end else if (reply_rdy) begin
            state <= REPLY;
            quota <= '0;
          end
        end
        SAMPLE: begin
          if (xfer) begin
            if (bcnt == BCNT_LAST) begin
              state <= IDLE;
              bcnt  <= '0;
              if (quota != '0) quota <= quota - 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        REPLY: begin
          if (xfer) begin
            if (out_end) begin
              state <= IDLE;
              rcnt  <= '0;
              quota <= QUOTA_LOAD;
              // Forced end at the length limit: the rest arrives as a new packet.
              if (rcnt_last && !reply_end) reply_overrun <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
